// File: rtl/calculation_unit_fraction_divider_if.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : calculation_unit_fraction_divider_if                             |
// | Brief   : Operand/result handshake bundle for the fraction divider.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

interface calculation_unit_fraction_divider_if #(
  parameter int QUOTIENT_WIDTH = 49
);
  logic                      start_valid;
  logic                      start_ready;
  logic [23:0]               fraction_a;
  logic [23:0]               fraction_b;
  logic                      result_valid;
  logic                      result_ready;
  logic [QUOTIENT_WIDTH-1:0] fraction_quotient;
  logic                      divide_by_zero;

  modport master (
    output start_valid,
    output fraction_a,
    output fraction_b,
    output result_ready,
    input  start_ready,
    input  result_valid,
    input  fraction_quotient,
    input  divide_by_zero
  );

  modport slave (
    input  start_valid,
    input  fraction_a,
    input  fraction_b,
    input  result_ready,
    output start_ready,
    output result_valid,
    output fraction_quotient,
    output divide_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/calculation_unit_fraction_divider.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : calculation_unit_fraction_divider                                |
// | Brief   : Radix-2 restoring divider, 1.23 / 1.23 -> 2.(QW-2) plus sticky,  |
// |           one quotient bit per clock. Optional early termination on a     |
// |           zero remainder: CALCULATION_UNIT_DIVIDER_EARLY_TERMINATION_EN.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module calculation_unit_fraction_divider #(
  parameter int QUOTIENT_WIDTH = 49
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  calculation_unit_fraction_divider_if.slave   bus
);

  localparam int c_cnt_w = $clog2(QUOTIENT_WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(QUOTIENT_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DIV0 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                      r_ready_en;
  logic [23:0]               r_div;
  logic [25:0]               r_rem;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [QUOTIENT_WIDTH-1:0] r_q;
  logic [QUOTIENT_WIDTH-1:0] r_quotient;
  logic                      r_dbz;

  logic                      w_start_ready;
  logic                      w_result_valid;
  logic                      w_accept;
  logic                      w_b_zero;
  logic                      w_first;
  logic                      w_last;
  logic [25:0]               w_sub_op;
  logic [26:0]               w_diff;
  logic                      w_qbit;
  logic [25:0]               w_rem_sel;
  logic [25:0]               w_rem_next;
  logic                      w_rem_zero;
  logic                      w_run_finish;
  logic [QUOTIENT_WIDTH-1:0] w_q_upd;

  assign w_b_zero = (bus.fraction_b == 24'd0);
  assign w_accept = w_start_ready & bus.start_valid;

  // The first step weighs 2 (compare against 2b, no shift) so the remainder
  // afterwards is directly comparable with b at unit weight.
  always_comb begin
    w_first    = (r_cnt == c_cnt_init);
    w_last     = (r_cnt == '0);
    w_sub_op   = w_first ? {1'b0, r_div, 1'b0} : {2'b00, r_div};
    w_diff     = {1'b0, r_rem} - {1'b0, w_sub_op};
    w_qbit     = ~w_diff[26];
    w_rem_sel  = w_qbit ? w_diff[25:0] : r_rem;
    w_rem_next = w_first ? w_rem_sel : {w_rem_sel[24:0], 1'b0};
    w_rem_zero = (w_rem_sel == '0);
    w_q_upd        = r_q;
    w_q_upd[r_cnt] = w_qbit;
    if (w_last && !w_rem_zero) begin
      w_q_upd[0] = 1'b1;
    end
`ifdef CALCULATION_UNIT_DIVIDER_EARLY_TERMINATION_EN
    w_run_finish = w_last | w_rem_zero;
`else
    w_run_finish = w_last;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_start_ready  = 1'b0;
    w_result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start_ready = r_ready_en;
        if (r_ready_en && bus.start_valid) begin
          w_state_next = w_b_zero ? S_DIV0 : S_RUN;
        end
      end
      S_RUN: begin
        if (w_run_finish) begin
          w_state_next = S_DONE;
        end
      end
      S_DIV0: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        w_result_valid = 1'b1;
        if (bus.result_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // r_ready_en keeps start_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready_en <= 1'b0;
      r_div      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_q        <= '0;
      r_quotient <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_div <= bus.fraction_b;
        r_rem <= {2'b00, bus.fraction_a};
        r_cnt <= c_cnt_init;
        r_q   <= '0;
        if (w_b_zero) begin
          r_quotient <= '1;
          r_dbz      <= 1'b1;
        end
      end else if (r_state == S_RUN) begin
        r_rem <= w_rem_next;
        r_cnt <= r_cnt - c_cnt_w'(1);
        r_q   <= w_q_upd;
        if (w_run_finish) begin
          r_quotient <= w_q_upd;
          r_dbz      <= 1'b0;
        end
      end
    end
  end

  assign bus.start_ready       = w_start_ready;
  assign bus.result_valid      = w_result_valid;
  assign bus.fraction_quotient = r_quotient;
  assign bus.divide_by_zero    = r_dbz;

endmodule

`default_nettype wire
